// File: rtl/herald_pkg.sv
// herald_pkg
//   Shared types and constants for the herald command front end.
//   - opcode_e   : command opcodes carried in bits [1:0] of the opcode byte
//   - state_e    : front-end FSM states
//   - ACK_BYTE / ERR_OPCODE / ERR_TIMEOUT : fixed single-byte replies
//   - CNT_W      : width of operand/result byte counters
//   - operand_bytes / result_bytes : per-opcode byte counts
package herald_pkg;

    typedef enum logic [1:0] {
        OP_MAC     = 2'd0,
        OP_CORDIC  = 2'd1,
        OP_MAC_CLR = 2'd2,
        OP_STATUS  = 2'd3
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    localparam logic [7:0] ACK_BYTE    = 8'hA5;
    localparam logic [7:0] ERR_OPCODE  = 8'hEE;
    localparam logic [7:0] ERR_TIMEOUT = 8'hEF;

    // Enough for up to 15 operand or result bytes.
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] operand_bytes(input opcode_e op, input int data_w);
        case (op)
            OP_MAC:    return CNT_W'(2 * data_w / 8);
            OP_CORDIC: return CNT_W'(data_w / 8);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] result_bytes(input opcode_e op, input int data_w,
                                                      input int res_w);
        case (op)
            OP_MAC:    return CNT_W'(res_w / 8);
            OP_CORDIC: return CNT_W'(2 * data_w / 8);
            default:   return CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/herald_byte_serializer.sv
// herald_byte_serializer
//   Loads a wide word plus a byte count and emits it LSB-first, one byte per
//   valid/ready handshake.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     load                    capture load_word/load_count (only while idle)
//     load_word [W-1:0]       word to emit
//     load_count [CNT_W-1:0]  number of bytes to emit (0 emits nothing)
//     data [7:0]              current byte, stable while valid && !ready
//     valid                   byte available
//     ready                   consumer takes the byte when valid && ready
//     last                    current byte is the final one
//   Handshake: a byte transfers on any cycle where valid && ready are both
//   high; valid never drops and data never changes until that happens.
module herald_byte_serializer
    import herald_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_word,
    input  logic [CNT_W-1:0] load_count,
    output logic [7:0]       data,
    output logic             valid,
    input  logic             ready,
    output logic             last
);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            remaining <= '0;
            valid     <= 1'b0;
        end else if (load) begin
            shreg     <= load_word;
            remaining <= load_count;
            valid     <= (load_count != '0);
        end else if (valid && ready) begin
            shreg     <= shreg >> 8;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
                valid <= 1'b0;
            end
        end
    end

    assign data = shreg[7:0];
    assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/herald_cmd_frontend.sv
// herald_cmd_frontend
//   Byte-serial command front end for the MAC and CORDIC engines. Collects an
//   opcode byte plus LSB-first operand bytes, pulses the selected engine's
//   start, waits (bounded) for its done and streams the result LSB-first.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     in_data/in_valid/in_ready      host command bytes
//     out_data/out_valid/out_ready   result bytes toward the host
//     busy                           FSM not in IDLE
//     mac_start/mac_clear/mac_a/mac_b/mac_done/mac_acc   MAC engine
//     cordic_start/cordic_angle/cordic_done/cordic_cos/cordic_sin   CORDIC
//   Handshake: both byte streams transfer on a cycle where valid && ready are
//   high; a producer holds data and valid until the transfer happens.
module herald_cmd_frontend
    import herald_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              mac_start,
    output logic              mac_clear,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic              mac_done,
    input  logic [RES_W-1:0]  mac_acc,
    output logic              cordic_start,
    output logic [DATA_W-1:0] cordic_angle,
    input  logic              cordic_done,
    input  logic [DATA_W-1:0] cordic_cos,
    input  logic [DATA_W-1:0] cordic_sin
);

    localparam int OPND_W = 2 * DATA_W;
    localparam int SER_W  = (RES_W > OPND_W) ? RES_W : OPND_W;

    state_e           state;
    opcode_e          op;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] last_opnd;
    logic [OPND_W-1:0] opnd;
    logic [OPND_W-1:0] opnd_next;
    logic [7:0]       wait_cnt;
    logic             err_opcode;
    logic             err_timeout;
    logic             in_take;
    logic             match_done;
    logic             timed_out;
    logic             ser_load;
    logic [SER_W-1:0] ser_word;
    logic [CNT_W-1:0] ser_count;
    logic             ser_last;

    assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
    assign busy       = (state != S_IDLE);
    assign in_take    = in_valid && in_ready;
    // Bytes enter at the top, so after a full MAC frame A sits in the low
    // half and B in the high half; a CORDIC angle ends up in the high half.
    assign opnd_next  = {in_data, opnd[OPND_W-1:8]};
    assign last_opnd  = operand_bytes(op, DATA_W) - CNT_W'(1);
    assign match_done = (op == OP_MAC) ? mac_done : cordic_done;
    // WAIT lasts at most TIMEOUT_CYC cycles (counter values 0..TIMEOUT_CYC-1).
    assign timed_out  = (wait_cnt == 8'(TIMEOUT_CYC - 1));

    // Serializer load happens on the edge that enters SEND or ERR.
    always_comb begin
        ser_load  = 1'b0;
        ser_word  = '0;
        ser_count = '0;
        case (state)
            S_IDLE: begin
                if (in_take && in_data[7:2] != 6'd0) begin
                    ser_load  = 1'b1;
                    ser_word  = SER_W'(ERR_OPCODE);
                    ser_count = CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (op == OP_MAC_CLR) begin
                    ser_load  = 1'b1;
                    ser_word  = SER_W'(ACK_BYTE);
                    ser_count = CNT_W'(1);
                end else if (op == OP_STATUS) begin
                    ser_load  = 1'b1;
                    ser_word  = SER_W'({6'd0, err_timeout, err_opcode});
                    ser_count = CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A done on the final WAIT cycle takes priority over timeout.
                if (match_done) begin
                    ser_load  = 1'b1;
                    ser_word  = (op == OP_MAC) ? SER_W'(mac_acc)
                                               : SER_W'({cordic_sin, cordic_cos});
                    ser_count = result_bytes(op, DATA_W, RES_W);
                end else if (timed_out) begin
                    ser_load  = 1'b1;
                    ser_word  = SER_W'(ERR_TIMEOUT);
                    ser_count = CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op           <= OP_MAC;
            byte_cnt     <= '0;
            opnd         <= '0;
            wait_cnt     <= '0;
            err_opcode   <= 1'b0;
            err_timeout  <= 1'b0;
            mac_start    <= 1'b0;
            mac_clear    <= 1'b0;
            cordic_start <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            cordic_angle <= '0;
        end else begin
            mac_start    <= 1'b0;
            mac_clear    <= 1'b0;
            cordic_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_take) begin
                        byte_cnt <= '0;
                        if (in_data[7:2] != 6'd0) begin
                            err_opcode <= 1'b1;
                            state      <= S_ERR;
                        end else begin
                            op <= opcode_e'(in_data[1:0]);
                            case (opcode_e'(in_data[1:0]))
                                OP_MAC, OP_CORDIC: state <= S_LOAD;
                                OP_MAC_CLR: begin
                                    mac_clear <= 1'b1;
                                    state     <= S_ISSUE;
                                end
                                default: state <= S_ISSUE;
                            endcase
                        end
                    end
                end
                S_LOAD: begin
                    if (in_take) begin
                        opnd     <= opnd_next;
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt == last_opnd) begin
                            state <= S_ISSUE;
                            // Operands are captured with the start pulse so they
                            // stay put until the next issue.
                            if (op == OP_MAC) begin
                                mac_start <= 1'b1;
                                mac_a     <= opnd_next[DATA_W-1:0];
                                mac_b     <= opnd_next[OPND_W-1:DATA_W];
                            end else begin
                                cordic_start <= 1'b1;
                                cordic_angle <= opnd_next[OPND_W-1 -: DATA_W];
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (op == OP_MAC || op == OP_CORDIC) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        state <= S_SEND;
                        if (op == OP_STATUS) begin
                            err_opcode  <= 1'b0;
                            err_timeout <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (match_done) begin
                        state <= S_SEND;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_SEND, S_ERR: begin
                    if (out_valid && out_ready && ser_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    herald_byte_serializer #(
        .W(SER_W)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_word  (ser_word),
        .load_count (ser_count),
        .data       (out_data),
        .valid      (out_valid),
        .ready      (out_ready),
        .last       (ser_last)
    );

endmodule

// File: tb/tb_herald_cmd_frontend.sv
// tb_herald_cmd_frontend
//   Directed plus randomized command frames against a frame-level reference
//   model: expected reply bytes, engine operands, start pulse counts and the
//   cycle distance from issue to the first reply byte.
module tb_herald_cmd_frontend;

    localparam int DATA_W      = 16;
    localparam int RES_W       = 32;
    localparam int TIMEOUT_CYC = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              mac_start;
    logic              mac_clear;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_done;
    logic [RES_W-1:0]  mac_acc;
    logic              cordic_start;
    logic [DATA_W-1:0] cordic_angle;
    logic              cordic_done;
    logic [DATA_W-1:0] cordic_cos;
    logic [DATA_W-1:0] cordic_sin;

    herald_cmd_frontend #(
        .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy),
        .mac_start(mac_start), .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b),
        .mac_done(mac_done), .mac_acc(mac_acc),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cmd_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int bp_mode   = 0;     // 0: always ready, 1: toggle, 2: random
    bit eng_en    = 1'b1;  // engine answers start with done
    int eng_delay = 0;     // WAIT cycle index on which done is driven

    bit m_err_op = 1'b0;
    bit m_err_to = 1'b0;

    int n_mac_start = 0;
    int n_cor_start = 0;
    int n_mac_clear = 0;

    int exp_mac, exp_cor, exp_clr, exp_lat;
    logic [DATA_W-1:0] exp_a, exp_b, exp_ang;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- output monitor ----------------
    bit         stalled = 1'b0;
    logic [7:0] held_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(held_byte));
            end
            stalled   = out_valid && !out_ready;
            held_byte = out_data;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (mac_start)    n_mac_start++;
            if (cordic_start) n_cor_start++;
            if (mac_clear)    n_mac_clear++;
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       out_ready = !out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- engine model ----------------
    // On a start it first pulses the other engine's done (a decoy that must be
    // ignored) when the delay allows, then its own done on WAIT cycle eng_delay.
    initial begin
        logic is_mac;
        mac_done    = 1'b0;
        cordic_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (mac_start || cordic_start) && eng_en) begin
                is_mac = mac_start;
                @(posedge clk);
                #1;
                if (eng_delay > 0) begin
                    if (is_mac) cordic_done = 1'b1; else mac_done = 1'b1;
                    @(posedge clk);
                    #1;
                    mac_done    = 1'b0;
                    cordic_done = 1'b0;
                    repeat (eng_delay - 1) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (is_mac) mac_done = 1'b1; else cordic_done = 1'b1;
                @(posedge clk);
                #1;
                mac_done    = 1'b0;
                cordic_done = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_cmd();
        logic [7:0] b0;
        bit         answered;
        b0 = cmd_q[0];
        exp_q.delete();
        exp_mac = 0; exp_cor = 0; exp_clr = 0; exp_lat = 1;
        answered = eng_en && (eng_delay < TIMEOUT_CYC);
        if (b0[7:2] != 6'd0) begin
            exp_q.push_back(8'hEE);
            m_err_op = 1'b1;
            exp_lat  = 0;
        end else begin
            case (b0[1:0])
                2'd0: begin
                    exp_mac = 1;
                    exp_a   = {cmd_q[2], cmd_q[1]};
                    exp_b   = {cmd_q[4], cmd_q[3]};
                    if (answered) begin
                        for (int i = 0; i < RES_W / 8; i++) exp_q.push_back(8'(mac_acc >> (8 * i)));
                        exp_lat = eng_delay + 2;
                    end else begin
                        exp_q.push_back(8'hEF);
                        m_err_to = 1'b1;
                        exp_lat  = TIMEOUT_CYC + 1;
                    end
                end
                2'd1: begin
                    exp_cor = 1;
                    exp_ang = {cmd_q[2], cmd_q[1]};
                    if (answered) begin
                        for (int i = 0; i < DATA_W / 8; i++) exp_q.push_back(8'(cordic_cos >> (8 * i)));
                        for (int i = 0; i < DATA_W / 8; i++) exp_q.push_back(8'(cordic_sin >> (8 * i)));
                        exp_lat = eng_delay + 2;
                    end else begin
                        exp_q.push_back(8'hEF);
                        m_err_to = 1'b1;
                        exp_lat  = TIMEOUT_CYC + 1;
                    end
                end
                2'd2: begin
                    exp_clr = 1;
                    exp_q.push_back(8'hA5);
                end
                default: begin
                    exp_q.push_back({6'd0, m_err_to, m_err_op});
                    m_err_op = 1'b0;
                    m_err_to = 1'b0;
                end
            endcase
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int t;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 400) begin
            @(negedge clk);
            acc = in_ready;
            t++;
            if (!acc) begin
                @(posedge clk);
                #1;
            end
        end
        if (!acc) check_eq("in_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_frame();
        int b_mac, b_cor, b_clr, lat;
        bit fin;
        model_cmd();
        got_q.delete();
        b_mac = n_mac_start;
        b_cor = n_cor_start;
        b_clr = n_mac_clear;
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
        // Now one cycle after the final command byte was accepted.
        if (exp_mac != 0) begin
            check_eq("mac_start_lat", 32'(mac_start), 32'd1);
            check_eq("mac_a", 32'(mac_a), 32'(exp_a));
            check_eq("mac_b", 32'(mac_b), 32'(exp_b));
        end
        if (exp_cor != 0) begin
            check_eq("cordic_start_lat", 32'(cordic_start), 32'd1);
            check_eq("cordic_angle", 32'(cordic_angle), 32'(exp_ang));
        end
        if (exp_clr != 0) check_eq("mac_clear_lat", 32'(mac_clear), 32'd1);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("first_out_lat", 32'(lat), 32'(exp_lat));
        fin = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge clk);
            if (got_q.size() >= exp_q.size() && !busy) fin = 1'b1;
        end
        if (!fin) check_eq("frame_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check_eq("out_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq("out_byte", 32'(got_q[i]), 32'(exp_q[i]));
        end
        check_eq("n_mac_start", 32'(n_mac_start - b_mac), 32'(exp_mac));
        check_eq("n_cordic_start", 32'(n_cor_start - b_cor), 32'(exp_cor));
        check_eq("n_mac_clear", 32'(n_mac_clear - b_clr), 32'(exp_clr));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] op_byte;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        mac_acc    = '0;
        cordic_cos = '0;
        cordic_sin = '0;
        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_starts", 32'({mac_start, mac_clear, cordic_start}), 32'd0);
        check_eq("rst_operands", 32'({mac_a, mac_b} | 32'(cordic_angle)), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MAC 3*4
        cmd_q = {8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        mac_acc = 32'h0000_000C; eng_delay = 3;
        do_frame();
        check_eq("mac_a_const", 32'(mac_a), 32'h0003);
        check_eq("mac_b_const", 32'(mac_b), 32'h0004);

        // CORDIC with toggling out_ready
        bp_mode = 1;
        cmd_q = {8'h01, 8'h00, 8'h20};
        cordic_cos = 16'h4000; cordic_sin = 16'h1234; eng_delay = 1;
        do_frame();
        bp_mode = 0;

        // Bad opcode then two STATUS reads
        cmd_q = {8'h84}; do_frame();
        cmd_q = {8'h03}; do_frame();
        cmd_q = {8'h03}; do_frame();

        // Timeout with no done, then STATUS
        eng_en = 1'b0;
        cmd_q = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        do_frame();
        eng_en = 1'b1;
        cmd_q = {8'h03}; do_frame();

        // Done on the last WAIT cycle wins; one cycle later is a timeout
        mac_acc = 32'hDEAD_BEEF; eng_delay = TIMEOUT_CYC - 1;
        cmd_q = {8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        do_frame();
        eng_delay = TIMEOUT_CYC;
        cmd_q = {8'h01, 8'h55, 8'hAA};
        do_frame();
        cmd_q = {8'h03}; do_frame();

        // MAC_CLR
        cmd_q = {8'h02}; do_frame();

        // Reset in the middle of a MAC frame
        eng_delay = 2;
        cmd_q = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_byte(cmd_q[0]);
        send_byte(cmd_q[1]);
        send_byte(cmd_q[2]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_mac_a", 32'(mac_a), 32'd0);
        check_eq("midrst_mac_b", 32'(mac_b), 32'd0);
        m_err_op = 1'b0;
        m_err_to = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mac_acc = 32'h0102_0304;
        cmd_q = {8'h00, 8'h05, 8'h00, 8'h06, 8'h00};
        do_frame();

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 9) == 0)
                op_byte = {6'($urandom_range(1, 63)), 2'($urandom)};
            else
                op_byte = {6'd0, 2'($urandom_range(0, 3))};
            cmd_q.delete();
            cmd_q.push_back(op_byte);
            if (op_byte[7:2] == 6'd0 && op_byte[1:0] == 2'd0)
                repeat (4) cmd_q.push_back(8'($urandom));
            if (op_byte[7:2] == 6'd0 && op_byte[1:0] == 2'd1)
                repeat (2) cmd_q.push_back(8'($urandom));
            eng_en     = ($urandom_range(0, 9) != 0);
            eng_delay  = $urandom_range(0, 6);
            mac_acc    = 32'($urandom);
            cordic_cos = 16'($urandom);
            cordic_sin = 16'($urandom);
            bp_mode    = $urandom_range(0, 2);
            do_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/herald_cmd_frontend.md
Name: herald_cmd_frontend

Overview:
Byte-serial command front end sitting directly upstream of the MAC and CORDIC engines inside tt_um_herald. It assembles opcode/operand bytes from the pin-level byte stream and issues a one-cycle start to the selected engine. It then waits for the engine's done, with a timeout. Finally it streams the result back out byte-wise, LSB first, over a valid/ready handshake toward uo_out.

Parameters:
DATA_W, 16, operand width for MAC A/B and CORDIC angle (byte multiple)
RES_W, 32, MAC accumulator width; CORDIC result = {sin, cos}, each DATA_W
TIMEOUT_CYC, 255, max cycles in WAIT before timeout error (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  8  command/operand byte
in_valid  in  1  host byte valid
in_ready  out  1  front end accepts byte (transfer = in_valid & in_ready)
out_data  out  8  result byte
out_valid  out  1  result byte valid
out_ready  in  1  host consumes result byte
busy  out  1  high in any state other than IDLE
mac_start  out  1  one-cycle pulse: accumulate mac_a*mac_b
mac_clear  out  1  one-cycle pulse: clear accumulator
mac_a  out  DATA_W  MAC operand A
mac_b  out  DATA_W  MAC operand B
mac_done  in  1  MAC completion pulse
mac_acc  in  RES_W  MAC accumulator value
cordic_start  out  1  one-cycle pulse: start CORDIC
cordic_angle  out  DATA_W  CORDIC input angle
cordic_done  in  1  CORDIC completion pulse
cordic_cos  in  DATA_W  CORDIC cosine
cordic_sin  in  DATA_W  CORDIC sine

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except in_ready=1; operand registers, byte counter and timeout counter cleared. Reset mid-frame or mid-WAIT discards everything; engine done pulses arriving during reset are ignored.
- Opcode byte in_data[1:0]: 0=MAC, 1=CORDIC, 2=MAC_CLR, 3=STATUS. in_data[7:2] must be 0.
- Operand bytes, LSB first: MAC = A then B (2*DATA_W/8 bytes); CORDIC = angle (DATA_W/8 bytes); MAC_CLR and STATUS take none.
- States:
  - IDLE: in_ready=1. An accepted opcode goes to LOAD if it has operands, else ISSUE. A nonzero in_data[7:2] goes to ERR with code 0xEE.
  - LOAD: in_ready=1; shift each accepted byte into the operand register; byte counter increments. After the last byte, go to ISSUE. in_valid gaps are allowed without limit.
  - ISSUE (1 cycle): in_ready=0. Pulse mac_start, cordic_start or mac_clear for exactly one cycle. mac_a, mac_b and cordic_angle are stable from ISSUE until the next ISSUE. MAC/CORDIC go to WAIT. MAC_CLR goes to SEND with byte 0xA5. STATUS goes to SEND with byte {6'b0, last_err_timeout, last_err_opcode}; both flags clear on the STATUS read.
  - WAIT: timeout counter runs from 0. The matching done (mac_done for MAC, cordic_done for CORDIC) latches the result into the output shift register and goes to SEND. The non-matching done is ignored. If the counter reaches TIMEOUT_CYC with no done, go to ERR with code 0xEF and set last_err_timeout. Done on the same cycle as the counter reaching TIMEOUT_CYC: done wins.
  - SEND: out_valid=1, out_data = current byte. Byte and out_valid are held stable until out_ready. On out_valid&out_ready advance; after the last byte (MAC RES_W/8 bytes; CORDIC cos LSB..MSB then sin LSB..MSB; 1 byte for MAC_CLR/STATUS) go to IDLE. out_valid drops the cycle after the final handshake.
  - ERR: single byte, SEND rules. Goes to IDLE. An opcode error also sets last_err_opcode.
- No input bytes are accepted outside IDLE/LOAD. Host bytes offered then stall.
- Latency: last operand byte accepted at cycle N; start pulse at N+1; first out_valid the cycle after done is sampled.

Decomposition:
- Shared package herald_pkg: opcode enum (OP_MAC, OP_CORDIC, OP_MAC_CLR, OP_STATUS), state enum, constants ACK_BYTE=0xA5, ERR_OPCODE=0xEE, ERR_TIMEOUT=0xEF, per-opcode operand/result byte counts.
- One natural sub-module: herald_byte_serializer (load wide word plus byte count, emit LSB-first bytes under valid/ready). Reuse it for result and error bytes.

Test Plan:
- MAC: bytes 0x00,0x03,0x00,0x04,0x00; engine returns mac_done with mac_acc=0x0000000C. Expect exactly one mac_start cycle with mac_a=0x0003, mac_b=0x0004; out bytes 0x0C,0x00,0x00,0x00.
- CORDIC with backpressure: 0x01,0x00,0x20; cordic_cos=0x4000, cordic_sin=0x1234; out_ready toggled every other cycle. Expect out bytes 0x00,0x40,0x34,0x12, held stable while stalled, none duplicated or dropped.
- Bad opcode 0x84 -> single out byte 0xEE. A following STATUS (0x03) returns 0x01, and a second STATUS returns 0x00.
- Timeout: MAC frame with no mac_done. After TIMEOUT_CYC cycles in WAIT, out byte 0xEF; STATUS returns 0x02. Variant: done on the final timeout cycle yields the result, not 0xEF.
- MAC_CLR (0x02) -> one mac_clear pulse, out byte 0xA5, no mac_start.
- rst_n asserted after 2 operand bytes of a MAC frame. Outputs return to reset values asynchronously. A fresh full MAC frame then completes correctly.
